cabac_value_refill: RTL
=======================

# cabac_value_refill

Stateful arithmetic-decoder register stage for the VVC CABAC decoder. It holds the architectural `m_range`, `m_value` and `bitsNeeded` registers, and runs the two-byte initialisation from the bitstream. It accepts per-bin results (new range, pre-shifted value, renormalisation shift) from the combinational regular-bin decoder and refills `m_value` with bitstream bytes through a valid/ready byte stream. Its outputs feed the regular-bin decoder's `m_range_in`/`m_value_in` for the next bin.

## Interface
- `INIT_RANGE`, default 510: range loaded after initialisation.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  single-cycle pulse; begins slice/arithmetic-decoder initialisation
- `byte_valid`  in  1  bitstream byte available
- `byte_data`  in  8  bitstream byte
- `byte_ready`  out  1  byte consumed this cycle when high together with `byte_valid`
- `dec_valid`  in  1  bin result presented
- `dec_ready`  out  1  result accepted this cycle when high together with `dec_valid`
- `dec_num_bits`  in  3  renormalisation shift, 0..6
- `dec_range`  in  9  updated range
- `dec_value`  in  16  value already left-shifted by `dec_num_bits`
- `state_valid`  out  1  `m_range_out`/`m_value_out` are current and usable for the next bin
- `m_range_out`  out  9  registered range
- `m_value_out`  out  16  registered value

## Operation
- FSM states and transitions:
  - IDLE → INIT_HI on `start`.
  - INIT_HI → INIT_LO on byte handshake.
  - INIT_LO → READY on byte handshake.
  - READY → REFILL on stall (below).
  - REFILL → READY on byte handshake.
- INIT_HI: `byte_ready`=1; handshake loads `value[15:8]`=byte.
- INIT_LO: `byte_ready`=1; handshake loads `value[7:0]`=byte, `range`=INIT_RANGE, `bitsNeeded`=−8.
- `bitsNeeded` is a 4-bit signed register. At rest it holds −8..−1.
- In READY, `dec_ready`=1. On a dec handshake, compute `bn = bitsNeeded + dec_num_bits` (range −8..+5) and always set `range` ← `dec_range`. Then:
  - `bn` < 0: `value` ← `dec_value`, `bitsNeeded` ← `bn`; stay READY; `byte_ready`=0.
  - `bn` ≥ 0 and `byte_valid`: `byte_ready`=1 in the same cycle; `value` ← `dec_value + (byte_data << bn)` (16-bit add, truncated); `bitsNeeded` ← `bn − 8`; stay READY.
  - `bn` ≥ 0 and no byte: latch `dec_value` and `bn`; go to REFILL.
- REFILL: `byte_ready`=1 and `dec_ready`=0. On handshake, `value` ← latched value + (byte << latched `bn`) and `bitsNeeded` ← `bn − 8`; return to READY.
- `byte_ready` is never high outside INIT_HI, INIT_LO, REFILL, or the same-cycle READY refill case.
- `start` in any state except IDLE aborts the current operation, discards any latched refill and enters INIT_HI. It is not accepted in the same cycle as a dec handshake: `dec_ready` is forced to 0 while `start` is high.
- `dec_num_bits`=0 is a legal no-op shift. Values 7 or greater are illegal; `dec_num_bits` is taken mod 8 without checking.

## Timing
- Reset values: FSM=IDLE, `state_valid`=0, `byte_ready`=0, `dec_ready`=0, `m_range_out`=0, `m_value_out`=0, `bitsNeeded`=−8.
- `state_valid` is a registered-state decode, equal to FSM==READY. It has no combinational path from inputs.
- Dec-to-state latency is 1 cycle when no stall occurs: a bin accepted at edge N gives a valid state at N+1, so one bin per cycle is possible.
- Stall latency is 1 cycle after the byte handshake in REFILL.
- Initialisation: `state_valid` rises the cycle after the second byte handshake, so the minimum is 3 cycles after `start`.
- `rst` overrides `start` and all handshakes.

## Configuration
- `CABAC_REFILL_STATS_EN` defined: adds output `stat_bytes` (32 bits, count of consumed bytes) and output `stat_stall_cycles` (32 bits, cycles spent in REFILL). Both are cleared by `rst` and by `start`, and saturate at their maximum.
- `CABAC_REFILL_STATS_EN` undefined: neither port nor either counter exists; all other behaviour is identical.

## Structure
- The shared CABAC package holds:
  - FSM state enum (IDLE, INIT_HI, INIT_LO, READY, REFILL)
  - constants `CABAC_RANGE_W`=9, `CABAC_VALUE_W`=16, `CABAC_BN_INIT`=−8
- One sub-module, `cabac_byte_merge`: a combinational `value + (byte << bn)` unit with a 3-bit shift, instantiated once and shared by the READY and REFILL paths through an input mux.

## Test plan
- Init: `start`, then bytes 0xA5 and 0x3C back-to-back → `state_valid`=1 at cycle 3 with value 0xA53C, range 510, `bitsNeeded`=−8.
- No refill: from init, dec `num_bits`=3, `dec_value`=0x29E0, `dec_range`=0x1F0 → next cycle value 0x29E0, range 0x1F0, `bitsNeeded`=−5, no byte consumed.
- Same-cycle refill: `bitsNeeded`=−5, `num_bits`=6, `dec_value`=0x4C00, byte 0xFF valid → `byte_ready` high that cycle; value 0x4DFE, `bitsNeeded`=−7.
- Stall: as the previous case but `byte_valid` held low for 4 cycles → REFILL, `state_valid`=0 for 5 cycles, `dec_ready`=0 throughout; byte 0x01 then gives value 0x4C02.
- Mid-operation restart and reset: `start` while in REFILL → latched value discarded, re-init from the next two bytes. `rst` during INIT_LO → IDLE, all outputs at their reset values the next cycle.
- Back-to-back: 8 consecutive bins with `num_bits`=1 and bytes always valid → one byte consumed exactly on the 8th bin; `state_valid` stays high every cycle.

Source files
------------

// File: rtl/cabac_value_refill_pkg.sv
// -----------------------------------------------------------------------------
// cabac_value_refill_pkg
// Shared CABAC decoder definitions: register widths, the bitsNeeded reset and
// initialisation value, and the state encoding of the value/refill FSM.
// -----------------------------------------------------------------------------
package cabac_value_refill_pkg;

    localparam int CABAC_RANGE_W = 9;
    localparam int CABAC_VALUE_W = 16;
    localparam logic signed [3:0] CABAC_BN_INIT = -4'sd8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT_HI = 3'd1,
        INIT_LO = 3'd2,
        READY   = 3'd3,
        REFILL  = 3'd4
    } cabac_state_t;

endpackage

// File: rtl/cabac_value_refill_byte_merge.sv
// -----------------------------------------------------------------------------
// cabac_byte_merge
// Combinational merge of one bitstream byte into the arithmetic-decoder value:
// o_value = i_value + (i_byte << i_shift), truncated to the value width.
//   i_value  [15:0]  value the byte is merged into
//   i_byte   [7:0]   bitstream byte
//   i_shift  [2:0]   left shift applied to the byte
//   o_value  [15:0]  merged value
// -----------------------------------------------------------------------------
module cabac_byte_merge
    import cabac_value_refill_pkg::*;
(
    input  logic [CABAC_VALUE_W-1:0] i_value,
    input  logic [7:0]               i_byte,
    input  logic [2:0]               i_shift,
    output logic [CABAC_VALUE_W-1:0] o_value
);

    logic [CABAC_VALUE_W-1:0] w_byte_ext;

    assign w_byte_ext = {{(CABAC_VALUE_W-8){1'b0}}, i_byte};
    assign o_value    = i_value + (w_byte_ext << i_shift);

endmodule

// File: rtl/cabac_value_refill.sv
// -----------------------------------------------------------------------------
// cabac_value_refill
// Register stage of the CABAC arithmetic decoder. Holds m_range, m_value and
// bitsNeeded, performs the two-byte initialisation from the bitstream and
// refills m_value with bitstream bytes after each regular bin.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    pulse: (re)start arithmetic-decoder initialisation
//   byte_valid/byte_data     bitstream byte stream in; byte_ready accepts it
//   dec_valid/dec_ready      bin result handshake from the regular-bin decoder
//   dec_num_bits/range/value renormalisation shift, new range, pre-shifted value
//   state_valid              m_range_out/m_value_out usable for the next bin
//   m_range_out, m_value_out registered range and value
//
// Optional build macro CABAC_REFILL_STATS_EN adds stat_bytes (consumed bytes)
// and stat_stall_cycles (cycles spent in REFILL), both saturating and cleared
// by rst and start.
// -----------------------------------------------------------------------------
module cabac_value_refill
    import cabac_value_refill_pkg::*;
#(
    parameter int INIT_RANGE = 510
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [2:0]               dec_num_bits,
    input  logic [CABAC_RANGE_W-1:0] dec_range,
    input  logic [CABAC_VALUE_W-1:0] dec_value,
`ifdef CABAC_REFILL_STATS_EN
    output logic [31:0]              stat_bytes,
    output logic [31:0]              stat_stall_cycles,
`endif
    output logic                     state_valid,
    output logic [CABAC_RANGE_W-1:0] m_range_out,
    output logic [CABAC_VALUE_W-1:0] m_value_out
);

    cabac_state_t             r_state;
    cabac_state_t             w_state_nxt;
    logic [CABAC_RANGE_W-1:0] r_range;
    logic [CABAC_VALUE_W-1:0] r_value;
    logic signed [3:0]        r_bits_needed;
    logic [CABAC_VALUE_W-1:0] r_refill_value;
    logic [2:0]               r_refill_bn;

    logic signed [4:0]        w_bn;
    logic                     w_bn_neg;
    logic                     w_dec_ready;
    logic                     w_byte_ready;
    logic                     w_dec_hs;
    logic                     w_byte_hs;
    logic                     w_in_refill;
    logic [CABAC_VALUE_W-1:0] w_merge_base;
    logic [2:0]               w_merge_shift;
    logic [CABAC_VALUE_W-1:0] w_merged;

    // bitsNeeded + shift, one bit wider so -8 + 6 never wraps.
    assign w_bn     = {r_bits_needed[3], r_bits_needed} + $signed({2'b00, dec_num_bits});
    assign w_bn_neg = w_bn[4];

    assign w_dec_hs  = dec_valid && w_dec_ready;
    assign w_byte_hs = byte_valid && w_byte_ready;

    // The single merge unit serves the same-cycle READY refill and the
    // deferred REFILL completion.
    assign w_in_refill   = (r_state == REFILL);
    assign w_merge_base  = w_in_refill ? r_refill_value : dec_value;
    assign w_merge_shift = w_in_refill ? r_refill_bn    : w_bn[2:0];

    cabac_byte_merge u_merge (
        .i_value (w_merge_base),
        .i_byte  (byte_data),
        .i_shift (w_merge_shift),
        .o_value (w_merged)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_dec_ready  = 1'b0;
        w_byte_ready = 1'b0;
        if (start) begin
            // Restart wins over everything else; no handshake is offered.
            w_state_nxt = INIT_HI;
        end else begin
            case (r_state)
                INIT_HI: begin
                    w_byte_ready = 1'b1;
                    if (byte_valid) w_state_nxt = INIT_LO;
                end
                INIT_LO: begin
                    w_byte_ready = 1'b1;
                    if (byte_valid) w_state_nxt = READY;
                end
                READY: begin
                    w_dec_ready = 1'b1;
                    if (dec_valid && !w_bn_neg) begin
                        if (byte_valid) w_byte_ready = 1'b1;
                        else            w_state_nxt  = REFILL;
                    end
                end
                REFILL: begin
                    w_byte_ready = 1'b1;
                    if (byte_valid) w_state_nxt = READY;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_range       <= '0;
            r_value       <= '0;
            r_bits_needed <= CABAC_BN_INIT;
        end else begin
            r_state <= w_state_nxt;
            if (!start) begin
                case (r_state)
                    INIT_HI: begin
                        if (w_byte_hs) r_value[15:8] <= byte_data;
                    end
                    INIT_LO: begin
                        if (w_byte_hs) begin
                            r_value[7:0]  <= byte_data;
                            r_range       <= CABAC_RANGE_W'(INIT_RANGE);
                            r_bits_needed <= CABAC_BN_INIT;
                        end
                    end
                    READY: begin
                        if (w_dec_hs) begin
                            r_range <= dec_range;
                            if (w_bn_neg) begin
                                r_value       <= dec_value;
                                r_bits_needed <= w_bn[3:0];
                            end else if (byte_valid) begin
                                r_value       <= w_merged;
                                // bn in 0..7, so bn-8 in 4-bit two's complement is {1, bn}.
                                r_bits_needed <= {1'b1, w_bn[2:0]};
                            end
                        end
                    end
                    REFILL: begin
                        if (w_byte_hs) begin
                            r_value       <= w_merged;
                            r_bits_needed <= {1'b1, r_refill_bn};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stall capture: holds the pre-shifted value and shift until a byte arrives.
    always_ff @(posedge clk) begin
        if (r_state == READY && w_dec_hs && !w_bn_neg && !byte_valid) begin
            r_refill_value <= dec_value;
            r_refill_bn    <= w_bn[2:0];
        end
    end

`ifdef CABAC_REFILL_STATS_EN
    logic [31:0] r_stat_bytes;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_stat_bytes <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_byte_hs && (r_stat_bytes != 32'hFFFF_FFFF))
                r_stat_bytes <= r_stat_bytes + 32'd1;
            if (w_in_refill && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_bytes        = r_stat_bytes;
    assign stat_stall_cycles = r_stat_stall;
`endif

    assign byte_ready  = w_byte_ready;
    assign dec_ready   = w_dec_ready;
    assign state_valid = (r_state == READY);
    assign m_range_out = r_range;
    assign m_value_out = r_value;

endmodule
